// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter granting one shared up-counter to two requesters for len+1 cycles.
// Optional macro TIMER_ARB_ABORT_EN adds an `abort` input that ends a RUN early.
module delay_timer_arbiter #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] len0,
  input  logic [N-1:0] len1,
`ifdef TIMER_ARB_ABORT_EN
  input  logic         abort,
`endif
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         busy,
  output logic [N-1:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [N-1:0] target;
  logic [N-1:0] next_target;
  logic [N-1:0] next_count;
  logic         owner;
  logic         next_owner;
  logic         last_owner;
  logic         next_last_owner;
  logic         run_abort;

`ifdef TIMER_ARB_ABORT_EN
  assign run_abort = abort;
`else
  assign run_abort = 1'b0;
`endif

  // Next-state, arbitration and counter update.
  always_comb begin
    next_state      = state;
    next_count      = count;
    next_target     = target;
    next_owner      = owner;
    next_last_owner = last_owner;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          next_state = RUN;
          next_count = '0;
          // Contention goes to whoever did not own the previous job.
          if (req0 && req1) begin
            next_owner = ~last_owner;
          end else begin
            next_owner = req1;
          end
          next_target = next_owner ? len1 : len0;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if ((count == target) || run_abort) begin
          next_state = DONE;
        end else begin
          next_count = count + {{(N-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        next_state      = IDLE;
        next_last_owner = owner;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      target     <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      count      <= next_count;
      target     <= next_target;
      owner      <= next_owner;
      last_owner <= next_last_owner;
      gnt0       <= (next_state != IDLE) && !next_owner;
      gnt1       <= (next_state != IDLE) && next_owner;
      done0      <= (next_state == DONE) && !next_owner;
      done1      <= (next_state == DONE) && next_owner;
      busy       <= (next_state != IDLE);
    end
  end

endmodule

// File: doc/delay_timer_arbiter.md
DELAY_TIMER_ARBITER -- requirements
Module: delay_timer_arbiter

Interface
- REQ-001 Parameter N SHALL have default 8 and set the width of the shared up-counter and of both length inputs.
- REQ-002 Port `clock`, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
- REQ-003 Port `reset`, input, 1 bit, SHALL be the asynchronous, active-low reset (0 = reset asserted).
- REQ-004 Ports `req0`/`req1`, input, 1 bit each, SHALL be the level request of requester 0/1.
- REQ-005 Ports `len0`/`len1`, input, N bits each, SHALL be the requested terminal count of requester 0/1, sampled at grant.
- REQ-006 Ports `gnt0`/`gnt1`, output, 1 bit each, SHALL be high while the counter is owned by requester 0/1.
- REQ-007 Ports `done0`/`done1`, output, 1 bit each, SHALL be a one-cycle completion pulse to requester 0/1.
- REQ-008 Port `busy`, output, 1 bit, SHALL be high whenever the state is not IDLE.
- REQ-009 Port `count`, output, N bits, SHALL be the current shared counter value.

Function
- REQ-010 FSM states SHALL be IDLE, RUN, DONE.
- REQ-011 IDLE: if any req is high at a clock edge, the next state SHALL be RUN, with the winner's gnt high, len latched into an internal target, and count = 0.
- REQ-012 Arbitration SHALL be round-robin: with a single requester, grant it; with both, grant the one that is not last_owner.
- REQ-013 RUN: if count == target, the next state SHALL be DONE; otherwise count SHALL increment by 1.
- REQ-014 RUN SHALL therefore last exactly target+1 cycles; target = 0 gives a 1-cycle RUN.
- REQ-015 Maximum target 2^N-1 SHALL complete without wrap; count never wraps in RUN.
- REQ-016 DONE SHALL last 1 cycle, with the owner's done high and gnt still high. last_owner SHALL update to the owner and the next state SHALL be IDLE.
- REQ-017 In IDLE, gnt0, gnt1, done0 and done1 SHALL be low, and count SHALL hold its last value.
- REQ-018 Changes on req or len during RUN/DONE SHALL be ignored; a req still high in IDLE SHALL be treated as a new request.
- REQ-019 gnt0 and gnt1 SHALL never be high simultaneously, and likewise done0/done1.
- REQ-020 Minimum spacing between grants SHALL be one IDLE cycle, so back-to-back jobs alternate when both requesters are held high.

Reset
- REQ-021 While reset = 0, the state SHALL be IDLE, count = 0, target = 0, last_owner = 1, and all gnt/done/busy = 0, immediately and independent of clock.
- REQ-022 Reset asserted mid-RUN SHALL abandon the job with no done pulse; after release, arbitration SHALL restart with requester 0 favoured.

Configuration
- REQ-023 Macro TIMER_ARB_ABORT_EN defined SHALL add input `abort` (1 bit): abort high in RUN forces DONE next cycle (done pulse issued, count holds), and abort is ignored in IDLE/DONE.
- REQ-024 Macro TIMER_ARB_ABORT_EN undefined SHALL mean no `abort` port exists, and RUN ends only per REQ-013.

Verification
- REQ-025 Reset = 0 with random inputs SHALL hold all outputs 0 and state IDLE; on release with req0 = 1, len0 = 3, gnt0 SHALL rise after 1 edge.
- REQ-026 req0 = 1, len0 = 5 SHALL give count 0..5 over 6 RUN cycles, then done0 for 1 cycle, then busy = 0.
- REQ-027 req0 = req1 = 1 held, len = 2 each SHALL grant 0, 1, 0, 1 in order with no overlap of gnt or done.
- REQ-028 len1 = 0 SHALL give a 1-cycle RUN then done1; len0 = 8'hFF SHALL give 256 RUN cycles with count ending at 255 and no wrap.
- REQ-029 Reset pulsed low at count = 4 of len0 = 9 SHALL produce no done0 and count = 0 immediately.
- REQ-030 With TIMER_ARB_ABORT_EN, abort at count = 2 of len1 = 10 SHALL give done1 on the next cycle, count = 2, then IDLE.
